contador_regressivo_mmss: RTL and testbench



---
 rtl/contador_regressivo_mmss_pkg.sv | 10 +
 rtl/contador_regressivo_mmss_if.sv | 30 +++
 rtl/contador_regressivo_mmss_digito.sv | 19 +
 rtl/contador_regressivo_mmss.sv | 70 +++++++
 tb/tb_contador_regressivo_mmss.sv | 95 +++++++++
 5 files changed

// File: rtl/contador_regressivo_mmss_pkg.sv
// contador_regressivo_mmss_pkg: shared FSM state encoding and BCD constants
package contador_regressivo_mmss_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;
    localparam logic [3:0] DIGIT_MAX_UNITS = 4'd9;
endpackage

// File: rtl/contador_regressivo_mmss_if.sv
// contador_regressivo_mmss_if: control strobes, BCD presets and display/status outputs of the timer
// master: drives tick/load/start/pause and load_* presets, observes digits and status
// slave : the timer itself
interface contador_regressivo_mmss_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] load_min_tens;
    logic [3:0] load_min_units;
    logic [3:0] load_sec_tens;
    logic [3:0] load_sec_units;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       running;
    logic       zero;
    logic       done;
    modport master (
        output tick, load, start, pause,
        output load_min_tens, load_min_units, load_sec_tens, load_sec_units,
        input  min_tens, min_units, sec_tens, sec_units, running, zero, done
    );
    modport slave (
        input  tick, load, start, pause,
        input  load_min_tens, load_min_units, load_sec_tens, load_sec_units,
        output min_tens, min_units, sec_tens, sec_units, running, zero, done
    );
endinterface

// File: rtl/contador_regressivo_mmss_digito.sv
// digito_regressivo: one BCD down-counter digit, wraps 0 -> MAX with borrow, saturating load
// clk, clear (sync active-high), load/load_val preset, en borrow-in; q digit, borrow_out = en && q == 0
module digito_regressivo #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] q,
    output logic       borrow_out
);
    assign borrow_out = en && q == 4'd0;
    always_ff @(posedge clk)
        q <= clear ? 4'd0 :
             load  ? (load_val > MAX ? MAX : load_val) :
             en    ? (q == 4'd0 ? MAX : q - 4'd1) : q;
endmodule

// File: rtl/contador_regressivo_mmss.sv
// contador_regressivo_mmss: loadable MM:SS countdown timer with start/pause FSM and terminal pulse
// clk, clear (sync active-high reset); bus (slave): tick/load/start/pause, BCD presets,
// digit outputs, running, zero (count is 00:00), done (one-cycle pulse on run reaching 00:00)
module contador_regressivo_mmss
    import contador_regressivo_mmss_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5,
    parameter int SEC_TENS_MAX = 5
) (
    input logic clk,
    input logic clear,
    contador_regressivo_mmss_if.slave bus
);
    state_t     state;
    logic [3:0] mt, mu, st, su;
    logic       b_su, b_st, b_mu, b_mt;
    logic       load_acc, dec, at_one, preset_zero;
    assign load_acc    = bus.load && state != RUNNING;
    assign dec         = state == RUNNING && bus.tick && !bus.pause;
    // the decrement that lands on 00:00 is the terminal one
    assign at_one      = {mt, mu, st, su} == 16'h0001;
    // saturation never turns a nonzero digit into zero, so the raw presets decide
    assign preset_zero = {bus.load_min_tens, bus.load_min_units, bus.load_sec_tens, bus.load_sec_units} == 16'h0;
    digito_regressivo #(.MAX(DIGIT_MAX_UNITS)) u_su (
        .clk(clk), .clear(clear), .load(load_acc), .load_val(bus.load_sec_units),
        .en(dec), .q(su), .borrow_out(b_su)
    );
    digito_regressivo #(.MAX(4'(SEC_TENS_MAX))) u_st (
        .clk(clk), .clear(clear), .load(load_acc), .load_val(bus.load_sec_tens),
        .en(b_su), .q(st), .borrow_out(b_st)
    );
    digito_regressivo #(.MAX(DIGIT_MAX_UNITS)) u_mu (
        .clk(clk), .clear(clear), .load(load_acc), .load_val(bus.load_min_units),
        .en(b_st), .q(mu), .borrow_out(b_mu)
    );
    // min_tens borrow is never taken: a zero count has already left RUNNING
    digito_regressivo #(.MAX(4'(MIN_TENS_MAX))) u_mt (
        .clk(clk), .clear(clear), .load(load_acc), .load_val(bus.load_min_tens),
        .en(b_mu), .q(mt), .borrow_out(b_mt)
    );
    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= IDLE;
            bus.running <= 1'b0;
            bus.done    <= 1'b0;
            bus.zero    <= 1'b1;
        end else begin
            bus.done <= dec && at_one;
            if (load_acc) begin
                state       <= IDLE;
                bus.running <= 1'b0;
                bus.zero    <= preset_zero;
            end else if (dec && at_one) begin
                state       <= DONE;
                bus.running <= 1'b0;
                bus.zero    <= 1'b1;
            end else if (state == RUNNING && bus.pause) begin
                state       <= PAUSED;
                bus.running <= 1'b0;
            end else if ((state == IDLE || state == PAUSED) && bus.start && !bus.zero) begin
                state       <= RUNNING;
                bus.running <= 1'b1;
            end
        end
    end
    assign bus.min_tens  = mt;
    assign bus.min_units = mu;
    assign bus.sec_tens  = st;
    assign bus.sec_units = su;
endmodule

// File: tb/tb_contador_regressivo_mmss.sv
// tb_contador_regressivo_mmss: directed scoreboard bench for the MM:SS countdown timer
module tb_contador_regressivo_mmss;
    typedef struct {
        string       name;
        logic [15:0] digs;
        logic        running;
        logic        zero;
        logic        done;
    } exp_t;
    logic clk = 1'b0;
    logic clear = 1'b0;
    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    contador_regressivo_mmss_if bus ();
    contador_regressivo_mmss #(.MIN_TENS_MAX(5), .SEC_TENS_MAX(5)) dut (
        .clk(clk), .clear(clear), .bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        bus.tick = 0; bus.load = 0; bus.start = 0; bus.pause = 0;
        bus.load_min_tens = 0; bus.load_min_units = 0; bus.load_sec_tens = 0; bus.load_sec_units = 0;
    end
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            logic [15:0] got;
            e = sb.pop_front();
            got = {bus.min_tens, bus.min_units, bus.sec_tens, bus.sec_units};
            compared++;
            if (got !== e.digs || bus.running !== e.running || bus.zero !== e.zero || bus.done !== e.done) begin
                mismatched++;
                $display("FAIL %s: got %h running=%b zero=%b done=%b, expected %h running=%b zero=%b done=%b",
                         e.name, got, bus.running, bus.zero, bus.done, e.digs, e.running, e.zero, e.done);
            end
        end
    end
    task automatic step(input string nm, input logic c, tk, ld, st, ps, input logic [15:0] pre,
                        input logic [15:0] ed, input logic er, ez, edn);
        exp_t e;
        @(negedge clk);
        clear = c; bus.tick = tk; bus.load = ld; bus.start = st; bus.pause = ps;
        {bus.load_min_tens, bus.load_min_units, bus.load_sec_tens, bus.load_sec_units} = pre;
        e.name = nm; e.digs = ed; e.running = er; e.zero = ez; e.done = edn;
        sb.push_back(e);
    endtask
    initial begin
        //    name            clr tk ld st ps preset    exp      r  z  d
        step("reset",         1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
        step("start_zero",    0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
        step("load_sat",      0, 0, 1, 0, 0, 16'h9999, 16'h5959, 0, 0, 0);
        step("load_0100",     0, 0, 1, 1, 0, 16'h0100, 16'h0100, 0, 0, 0);
        step("start_0100",    0, 0, 0, 1, 0, 16'h0000, 16'h0100, 1, 0, 0);
        step("tick_0059",     0, 1, 0, 0, 0, 16'h0000, 16'h0059, 1, 0, 0);
        step("pause_0059",    0, 0, 0, 0, 1, 16'h0000, 16'h0059, 0, 0, 0);
        step("load_0002",     0, 0, 1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0);
        step("start_0002",    0, 0, 0, 1, 0, 16'h0000, 16'h0002, 1, 0, 0);
        step("tick_0001",     0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0);
        step("tick_0000",     0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1);
        step("done_drop",     0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
        step("done_tick",     0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
        step("done_start",    0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
        step("load_0530",     0, 0, 1, 0, 0, 16'h0530, 16'h0530, 0, 0, 0);
        step("start_0530",    0, 0, 0, 1, 0, 16'h0000, 16'h0530, 1, 0, 0);
        step("pause_tick",    0, 1, 0, 0, 1, 16'h0000, 16'h0530, 0, 0, 0);
        step("paused_tick",   0, 1, 0, 0, 0, 16'h0000, 16'h0530, 0, 0, 0);
        step("resume",        0, 0, 0, 1, 0, 16'h0000, 16'h0530, 1, 0, 0);
        step("tick_0529",     0, 1, 0, 0, 0, 16'h0000, 16'h0529, 1, 0, 0);
        step("pause_0529",    0, 0, 0, 0, 1, 16'h0000, 16'h0529, 0, 0, 0);
        step("load_347C",     0, 0, 1, 0, 0, 16'h347C, 16'h3459, 0, 0, 0);
        step("start_3459",    0, 0, 0, 1, 0, 16'h0000, 16'h3459, 1, 0, 0);
        step("run_load_ign",  0, 0, 1, 0, 0, 16'h0010, 16'h3459, 1, 0, 0);
        step("run_load_tick", 0, 1, 1, 0, 0, 16'h0010, 16'h3458, 1, 0, 0);
        step("pause_3458",    0, 0, 0, 0, 1, 16'h0000, 16'h3458, 0, 0, 0);
        step("load_1000",     0, 0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
        step("start_1000",    0, 0, 0, 1, 0, 16'h0000, 16'h1000, 1, 0, 0);
        step("tick_0959",     0, 1, 0, 0, 0, 16'h0000, 16'h0959, 1, 0, 0);
        step("tick_0958",     0, 1, 0, 0, 0, 16'h0000, 16'h0958, 1, 0, 0);
        step("pause_0958",    0, 0, 0, 0, 1, 16'h0000, 16'h0958, 0, 0, 0);
        step("load_1234",     0, 0, 1, 0, 0, 16'h1234, 16'h1234, 0, 0, 0);
        step("start_1234",    0, 0, 0, 1, 0, 16'h0000, 16'h1234, 1, 0, 0);
        step("clear_tick",    1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
        step("idle_tick",     0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
        @(negedge clk);
        clear = 0; bus.tick = 0; bus.load = 0; bus.start = 0; bus.pause = 0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
